// File: rtl/hex_scan_display.sv
// Registered multi-digit hex display driver: latches packed nibbles on load and drives
// a static per-digit segment bus plus a scanned segment/anode pair with blanking and blink.
module hex_scan_display #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned BLINK_LOG2   = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     blank_mask,
   input  logic                      lzs_en,
   input  logic                      blink_en,
   output logic [7*NUM_DIGITS-1:0]   hex_all,
   output logic [6:0]                seg,
   output logic [NUM_DIGITS-1:0]     an
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned VW = 4 * NUM_DIGITS;
   localparam int unsigned HW = 7 * NUM_DIGITS;
   localparam logic [6:0]  SEG_DARK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} hex glyphs
   function automatic logic [6:0] hex7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h18;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h27;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic [VW-1:0]         val_q;
   logic [NUM_DIGITS-1:0] mask_q;
   logic                  valid_q;
   logic [PW-1:0]         presc_q;
   logic [IW-1:0]         idx_q;
   logic [BLINK_LOG2-1:0] bcnt_q;
   logic                  phase_q;

   logic [HW-1:0]         hex_d;
   logic [6:0]            seg_sel;
   logic [6:0]            seg_d;
   logic [NUM_DIGITS-1:0] an_d;
   logic [3:0]            nib;
   logic                  zero_run;
   logic                  dark;
   logic                  blank_win;
   logic                  presc_last;
   logic                  idx_last;

   assign presc_last = (presc_q == PW'(SCAN_DIV - 1));
   assign idx_last   = (idx_q == IW'(NUM_DIGITS - 1));
   assign blank_win  = (presc_q < PW'(BLANK_CYCLES));

   // Per-digit glyph with darkening; zero_run tracks an all-zero prefix from the top digit
   always_comb begin
      hex_d    = '1;
      nib      = 4'h0;
      zero_run = 1'b1;
      dark     = 1'b0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         nib      = val_q[4*i +: 4];
         zero_run = zero_run & (nib == 4'h0);
         dark     = !valid_q || mask_q[i] || (blink_en && phase_q) ||
                    (lzs_en && zero_run && (i != 0));
         hex_d[7*i +: 7] = dark ? SEG_DARK : hex7(nib);
      end
   end

   // Scanned slot: dark gap at slot start, then the selected digit with its anode
   always_comb begin
      seg_sel = SEG_DARK;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx_q == IW'(i)) seg_sel = hex_d[7*i +: 7];
      end
      seg_d = blank_win ? SEG_DARK : seg_sel;
      an_d  = blank_win ? '1 : ~(NUM_DIGITS'(1) << idx_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q   <= '0;
         mask_q  <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         val_q   <= value;
         mask_q  <= blank_mask;
         valid_q <= 1'b1;
      end
   end

   // Slot prescaler, digit index and frame-counted blink phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         presc_q <= presc_last ? '0 : presc_q + PW'(1);
         if (presc_last) begin
            idx_q <= idx_last ? '0 : idx_q + IW'(1);
            if (idx_last) begin
               bcnt_q <= bcnt_q + BLINK_LOG2'(1);
               if (&bcnt_q) phase_q <= ~phase_q;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hex_all <= '1;
         seg     <= SEG_DARK;
         an      <= '1;
      end else begin
         hex_all <= hex_d;
         seg     <= seg_d;
         an      <= an_d;
      end
   end

endmodule
